// File: rtl/mu0_pkg.sv
// Shared definitions for the MU0 control unit: opcodes, ALU function codes,
// controller state encoding and the packed control word driven to the datapath.
package mu0_pkg;

    localparam int OP_W = 4;
    localparam int FS_W = 2;

    localparam logic [OP_W-1:0] OP_LDA = 4'h0;
    localparam logic [OP_W-1:0] OP_STA = 4'h1;
    localparam logic [OP_W-1:0] OP_ADD = 4'h2;
    localparam logic [OP_W-1:0] OP_SUB = 4'h3;
    localparam logic [OP_W-1:0] OP_JMP = 4'h4;
    localparam logic [OP_W-1:0] OP_JGE = 4'h5;
    localparam logic [OP_W-1:0] OP_JNE = 4'h6;
    localparam logic [OP_W-1:0] OP_STP = 4'h7;

    localparam logic [FS_W-1:0] FS_PASS_Y = 2'b00;
    localparam logic [FS_W-1:0] FS_ADD    = 2'b01;
    localparam logic [FS_W-1:0] FS_INC    = 2'b10;
    localparam logic [FS_W-1:0] FS_SUB    = 2'b11;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC  = 2'b01,
        ST_HALT  = 2'b10
    } state_e;

    typedef struct packed {
        logic            addr_sel;
        logic            x_sel;
        logic            y_sel;
        logic [FS_W-1:0] alu_fs;
        logic            acc_en;
        logic            pc_en;
        logic            ir_en;
        logic            rd;
        logic            wr;
        logic            halted;
    } ctrl_t;

    // LDA, STA, ADD and SUB are the only opcodes that touch memory in EXEC.
    function automatic logic isMemOp(input logic [OP_W-1:0] f);
        return (f <= OP_SUB);
    endfunction

endpackage

// File: rtl/mu0_decode.sv
// Combinational decoder: maps controller state, opcode, flags and memory
// ready into the control word for the MU0 datapath.
module mu0_decode
    import mu0_pkg::*;
(
    input  state_e          state_i,
    input  logic [OP_W-1:0] f_i,
    input  logic            n_i,
    input  logic            z_i,
    input  logic            memRdy_i,
    output ctrl_t           ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            ST_FETCH: begin
                ctrl_o.rd     = 1'b1;
                ctrl_o.alu_fs = FS_INC;
                ctrl_o.ir_en  = memRdy_i;
                ctrl_o.pc_en  = memRdy_i;
            end
            ST_EXEC: begin
                case (f_i)
                    OP_LDA: begin
                        ctrl_o.addr_sel = 1'b1;
                        ctrl_o.rd       = 1'b1;
                        ctrl_o.alu_fs   = FS_PASS_Y;
                        ctrl_o.acc_en   = memRdy_i;
                    end
                    OP_STA: begin
                        ctrl_o.addr_sel = 1'b1;
                        ctrl_o.wr       = 1'b1;
                    end
                    OP_ADD: begin
                        ctrl_o.addr_sel = 1'b1;
                        ctrl_o.rd       = 1'b1;
                        ctrl_o.x_sel    = 1'b1;
                        ctrl_o.alu_fs   = FS_ADD;
                        ctrl_o.acc_en   = memRdy_i;
                    end
                    OP_SUB: begin
                        ctrl_o.addr_sel = 1'b1;
                        ctrl_o.rd       = 1'b1;
                        ctrl_o.x_sel    = 1'b1;
                        ctrl_o.alu_fs   = FS_SUB;
                        ctrl_o.acc_en   = memRdy_i;
                    end
                    OP_JMP, OP_JGE, OP_JNE: begin
                        ctrl_o.y_sel  = 1'b1;
                        ctrl_o.alu_fs = FS_PASS_Y;
                        ctrl_o.pc_en  = (f_i == OP_JMP) ? 1'b1 :
                                        (f_i == OP_JGE) ? ~n_i : ~z_i;
                    end
                    default: ;
                endcase
            end
            ST_HALT: ctrl_o.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mu0_control.sv
// MU0 control unit: fetch/execute/halt sequencer with async active-low reset;
// the control word comes from mu0_decode and is forced to zero while in reset.
module mu0_control
    import mu0_pkg::*;
(
    input  logic            Clk,
    input  logic            Reset,
    input  logic [OP_W-1:0] F,
    input  logic            N,
    input  logic            Z,
    input  logic            Mem_Rdy,
    output logic            Addr_sel,
    output logic            X_sel,
    output logic            Y_sel,
    output logic [FS_W-1:0] ALU_fs,
    output logic            Acc_En,
    output logic            PC_En,
    output logic            IR_En,
    output logic            Rd,
    output logic            Wr,
    output logic            Halted
);

    state_e state_q;
    state_e state_d;
    ctrl_t  decCtrl;
    ctrl_t  ctrl;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state_q <= ST_FETCH;
        else        state_q <= state_d;
    end

    // Memory ops stall in EXEC until the memory completes; others take one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: if (Mem_Rdy) state_d = ST_EXEC;
            ST_EXEC: begin
                if (F == OP_STP)                  state_d = ST_HALT;
                else if (isMemOp(F) && !Mem_Rdy)  state_d = ST_EXEC;
                else                              state_d = ST_FETCH;
            end
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_FETCH;
        endcase
    end

    mu0_decode u_decode (
        .state_i  (state_q),
        .f_i      (F),
        .n_i      (N),
        .z_i      (Z),
        .memRdy_i (Mem_Rdy),
        .ctrl_o   (decCtrl)
    );

    // Outputs must fall to zero the moment reset asserts, not at the next edge.
    always_comb begin
        ctrl = decCtrl;
        if (!Reset) ctrl = '0;
    end

    assign Addr_sel = ctrl.addr_sel;
    assign X_sel    = ctrl.x_sel;
    assign Y_sel    = ctrl.y_sel;
    assign ALU_fs   = ctrl.alu_fs;
    assign Acc_En   = ctrl.acc_en;
    assign PC_En    = ctrl.pc_en;
    assign IR_En    = ctrl.ir_en;
    assign Rd       = ctrl.rd;
    assign Wr       = ctrl.wr;
    assign Halted   = ctrl.halted;

endmodule
